// File: rtl/alu_decode_if.sv
// alu_decode_if: instruction-in / decoded-beat-out handshake bundle for alu_decode_stage.
// master is the surrounding pipeline, slave is the decode stage.
interface alu_decode_if #(
    parameter int XLEN = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [4:0]       alu_control;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic             illegal;
    logic [CNT_W-1:0] decode_count;
    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, rs1, rs2, rd, alu_control, imm, use_imm, illegal, decode_count
    );
    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, rs1, rs2, rd, alu_control, imm, use_imm, illegal, decode_count
    );
endinterface

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: one-deep registered decode of R-type / OP-IMM ALU instructions
// with valid/ready handshake, flush, and a saturating count of legal beats delivered.
module alu_decode_stage #(
    parameter int XLEN = 32,
    parameter int EN_IMM = 1,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    alu_decode_if.slave bus
);
    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
                           ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                           ALU_OR = 5'd8, ALU_AND = 5'd9;
    // func3-indexed op table shared by R-type (func7=0) and OP-IMM
    localparam logic [7:0][4:0] ROP = {ALU_AND, ALU_OR, ALU_SRL, ALU_XOR, ALU_SLTU, ALU_SLT, ALU_SLL, ALU_ADD};

    logic [6:0]       w_op, w_f7;
    logic [2:0]       w_f3;
    logic [4:0]       w_rop, w_alu;
    logic             w_hi_zero, w_hi_sra, w_legal, w_imm_op, w_in_ready, w_cap, w_fire;
    logic [XLEN-1:0]  w_sext;
    logic             r_valid, r_use_imm, r_illegal;
    logic [4:0]       r_rs1, r_rs2, r_rd, r_alu;
    logic [XLEN-1:0]  r_imm;
    logic [CNT_W-1:0] r_count;

    assign w_op = bus.instruction[6:0];
    assign w_f3 = bus.instruction[14:12];
    assign w_f7 = bus.instruction[31:25];
    assign w_rop = ROP[w_f3];
    assign w_sext = {{(XLEN-12){bus.instruction[31]}}, bus.instruction[31:20]};
    // bits above the shamt field: [31:25] on RV32, [31:26] on RV64
    assign w_hi_zero = (XLEN == 64) ? (bus.instruction[31:26] == 6'd0) : (bus.instruction[31:25] == 7'd0);
    assign w_hi_sra = (XLEN == 64) ? (bus.instruction[31:26] == 6'b010000) : (bus.instruction[31:25] == 7'b0100000);

    always_comb begin
        w_legal = 1'b0;
        w_alu = ALU_ADD;
        w_imm_op = 1'b0;
        if (w_op == 7'b0110011) begin
            w_legal = (w_f7 == 7'd0) || (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5));
            w_alu = w_f7[5] ? ((w_f3 == 3'd0) ? ALU_SUB : ALU_SRA) : w_rop;
        end else if (EN_IMM != 0 && w_op == 7'b0010011) begin
            w_imm_op = 1'b1;
            w_legal = (w_f3 == 3'd1) ? w_hi_zero : (w_f3 == 3'd5) ? (w_hi_zero || w_hi_sra) : 1'b1;
            w_alu = (w_f3 == 3'd5 && w_hi_sra) ? ALU_SRA : w_rop;
        end
    end

    assign w_in_ready = !rst && (!r_valid || bus.out_ready);
    assign w_cap = bus.in_valid && w_in_ready && !flush;
    assign w_fire = r_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_rd <= '0;
            r_alu <= ALU_ADD;
            r_imm <= '0;
            r_use_imm <= 1'b0;
            r_illegal <= 1'b0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else begin
            if (w_fire && !r_illegal && !(&r_count))
                r_count <= r_count + 1'b1;
            if (w_cap) begin
                r_valid <= 1'b1;
                r_rs1 <= bus.instruction[19:15];
                r_rs2 <= bus.instruction[24:20];
                r_rd <= w_legal ? bus.instruction[11:7] : 5'd0;
                r_alu <= w_legal ? w_alu : ALU_ADD;
                r_imm <= (w_legal && w_imm_op) ? w_sext : '0;
                r_use_imm <= w_legal && w_imm_op;
                r_illegal <= !w_legal;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.rs1 = r_rs1;
    assign bus.rs2 = r_rs2;
    assign bus.rd = r_rd;
    assign bus.alu_control = r_alu;
    assign bus.imm = r_imm;
    assign bus.use_imm = r_use_imm;
    assign bus.illegal = r_illegal;
    assign bus.decode_count = r_count;
endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of imm (legal 32 or 64).
REQ-002 SHALL have parameter EN_IMM, default 1, enables OP-IMM (opcode 0010011) decoding; 0 makes OP-IMM illegal.
REQ-003 SHALL have parameter CNT_W, default 16, width of decode_count.
REQ-004 SHALL have ports, clock and reset first:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard held and incoming beats.
- in_valid  input  1  instruction beat present.
- in_ready  output  1  stage can accept a beat.
- instruction  input  32  raw instruction word.
- out_valid  output  1  decoded beat present.
- out_ready  input  1  downstream accepts the beat.
- rs1, rs2, rd  output  5 each  register indices.
- alu_control  output  5  ALU op code, team ALU define set (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- imm  output  XLEN  sign-extended I-immediate.
- use_imm  output  1  operand B is imm, not rs2.
- illegal  output  1  beat is not a legal R-type/OP-IMM ALU instruction.
- decode_count  output  CNT_W  legal beats delivered.

Function
REQ-005 SHALL register all decoded outputs: one-cycle latency from an accepted input beat to out_valid.
REQ-006 SHALL drive in_ready = !out_valid || out_ready (combinational), forced 0 while rst=1.
REQ-007 SHALL capture a beat when in_valid && in_ready && !flush; out_valid then 1 next cycle.
REQ-008 SHALL clear out_valid when out_valid && out_ready and no new beat is captured that cycle.
REQ-009 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-010 SHALL, on flush=1, clear out_valid next cycle and discard any input beat that cycle; flush has priority over capture and handoff; decode_count unaffected by flushed beats.
REQ-011 SHALL extract rd=[11:7], func3=[14:12], rs1=[19:15], rs2=[24:20], func7=[31:25].
REQ-012 SHALL decode opcode 0110011: func7 0000000 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND per func3 0..7; func7 0100000 with func3 0 -> SUB, func3 5 -> SRA; any other func7/func3 pairing illegal; use_imm=0.
REQ-013 SHALL decode opcode 0010011 (EN_IMM=1): func3 0 -> ADD (never SUB); 2 SLT; 3 SLTU; 4 XOR; 6 OR; 7 AND; use_imm=1.
REQ-014 SHALL decode OP-IMM shifts: shamt width 5 (XLEN=32) or 6 (XLEN=64); func3 1 requires upper bits [31:20+shamt width] all 0 -> SLL; func3 5 with those bits 0 -> SRL, with [31:25]=0100000 (XLEN=32) or [31:26]=010000 (XLEN=64) -> SRA; otherwise illegal.
REQ-015 SHALL set imm = sign-extend instruction[31:20] to XLEN for OP-IMM, 0 for R-type.
REQ-016 SHALL treat every other opcode as illegal.
REQ-017 SHALL, for illegal beats, assert illegal=1, force rd=0, alu_control=ADD, use_imm=0, imm=0; rs1/rs2 still extracted; beat still handshaked normally.
REQ-018 SHALL increment decode_count on each output handoff (out_valid && out_ready && !flush) with illegal=0; saturate at 2^CNT_W-1, never wrap.

Reset
REQ-019 SHALL, when rst=1 at a rising edge, set out_valid=0, rs1=rs2=rd=0, alu_control=ADD, imm=0, use_imm=0, illegal=0, decode_count=0; rst overrides flush and any handshake.
REQ-020 SHALL accept no beat during the reset cycle (in_ready=0).

Verification
REQ-021 0x40B50533 in, out_ready=1 -> next cycle out_valid=1, rd=10, rs1=10, rs2=11, alu_control=SUB, use_imm=0, illegal=0; decode_count 0->1 on handoff.
REQ-022 0xFFF00293 (XLEN=64) -> rd=5, rs1=0, ADD, use_imm=1, imm=0xFFFFFFFFFFFFFFFF; 0x40335313 (XLEN=32) -> rd=6, rs1=6, SRA, imm=0x00000403.
REQ-023 0x02B50533 (func7 0000001) -> illegal=1, rd=0, alu_control=ADD; decode_count unchanged after handoff.
REQ-024 out_ready=0 for 5 cycles with out_valid=1 and in_valid=1 -> outputs stable, in_ready=0, no beat lost; out_ready=1 -> next beat appears following cycle.
REQ-025 flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, both beats dropped, decode_count unchanged; rst mid-stream -> all REQ-019 values next cycle.
REQ-026 CNT_W=2, five legal handoffs -> decode_count sequence 1,2,3,3,3.
